uart_mmio: RTL

// - Memory-mapped 8N1 UART responder on the CPU data bus (selected by cs_uart_n); the CPU is the initiator.
// - Drives UART_TXD and samples UART_RXD at BAUD_RATE derived from CLOCK_FREQ.
// - Single-byte TX holding register, single-byte RX buffer, status/flag register.
// - Read data is combinational, so it matches the async-read timing the CPU already uses for data RAM.

---
 rtl/uart_mmio_if.sv | 14 +
 rtl/uart_mmio.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/uart_mmio_if.sv
// CPU data-bus view of the UART register block: the CPU drives chip select,
// strobes, address and write data; the UART returns combinational read data.
interface uart_mmio_if;
  logic        cs_n;
  logic        we;
  logic        re;
  logic [3:0]  addr;
  logic [3:0]  byte_enable;
  logic [31:0] wdata;
  logic [31:0] rdata;

  modport master (output cs_n, we, re, addr, byte_enable, wdata, input rdata);
  modport slave  (input cs_n, we, re, addr, byte_enable, wdata, output rdata);
endinterface

// File: rtl/uart_mmio.sv
// Memory-mapped 8N1 UART: one-byte TX holding register, one-byte RX buffer
// and a status register with sticky overrun / framing-error flags.
// Read data is combinational so it fits the CPU's async-read data path.
module uart_mmio #(
  parameter int CLOCK_FREQ = 125_000_000,
  parameter int BAUD_RATE  = 115_200
) (
  input  logic           clk,
  input  logic           n_rst,
  uart_mmio_if.slave     bus,
  output logic           uart_txd,
  input  logic           uart_rxd
);
  localparam int CLKS_PER_BIT = CLOCK_FREQ / BAUD_RATE;
  localparam int CW = $clog2(CLKS_PER_BIT) + 1;
  typedef logic [CW-1:0] cnt_t;
  localparam cnt_t BIT_LAST  = cnt_t'(CLKS_PER_BIT - 1);
  localparam cnt_t HALF_LAST = cnt_t'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  tx_state_t tx_state_r, tx_next_s;
  rx_state_t rx_state_r, rx_next_s;
  cnt_t      tx_cnt_r, rx_cnt_r;
  logic [2:0] tx_idx_r, rx_idx_r;
  logic [7:0] tx_shift_r, rx_shift_r, rx_data_r;
  logic       tx_busy_r, txd_r, tx_txd_next_s, tx_bit_end_s;
  logic       rx_meta_r, rx_s_r, rx_sample_s, rx_done_s;
  logic       rx_valid_r, overrun_r, frame_err_r;
  logic       tx_accept_s, rx_read_s, status_wr_s, unused_s;

  // Bus decode: register index lives in addr[3:2], only byte lane 0 carries data.
  assign tx_accept_s = !bus.cs_n && bus.we && bus.byte_enable[0] &&
                       (bus.addr[3:2] == 2'd0) && !tx_busy_r;
  assign rx_read_s   = !bus.cs_n && bus.re && (bus.addr[3:2] == 2'd1);
  assign status_wr_s = !bus.cs_n && bus.we && bus.byte_enable[0] &&
                       (bus.addr[3:2] == 2'd2);
  assign unused_s    = ^{bus.wdata[31:8], bus.addr[1:0], bus.byte_enable[3:1]};
  assign uart_txd    = txd_r;

  // Combinational read mux; reserved and TXDATA slots read as zero.
  always_comb begin
    bus.rdata = 32'd0;
    case (bus.addr[3:2])
      2'd1:    bus.rdata = {24'd0, rx_data_r};
      2'd2:    bus.rdata = {28'd0, frame_err_r, overrun_r, rx_valid_r, tx_busy_r};
      default: bus.rdata = 32'd0;
    endcase
  end

  // TX next-state and next serial level; every state spans one full bit period.
  always_comb begin
    tx_next_s    = tx_state_r;
    tx_bit_end_s = (tx_cnt_r == BIT_LAST);
    case (tx_state_r)
      TX_IDLE:  tx_next_s = tx_accept_s ? TX_START : TX_IDLE;
      TX_START: tx_next_s = tx_bit_end_s ? TX_DATA : TX_START;
      TX_DATA:  tx_next_s = (tx_bit_end_s && tx_idx_r == 3'd7) ? TX_STOP : TX_DATA;
      TX_STOP:  tx_next_s = tx_bit_end_s ? TX_IDLE : TX_STOP;
      default:  tx_next_s = TX_IDLE;
    endcase
    case (tx_next_s)
      TX_START: tx_txd_next_s = 1'b0;
      TX_DATA:  tx_txd_next_s = (tx_state_r == TX_DATA && tx_bit_end_s) ?
                                tx_shift_r[1] : tx_shift_r[0];
      default:  tx_txd_next_s = 1'b1;
    endcase
  end

  // TX state register.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) tx_state_r <= TX_IDLE;
    else        tx_state_r <= tx_next_s;
  end

  // TX datapath: bit timer, bit index, LSB-first shifter, registered line and busy flag.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      tx_cnt_r   <= '0;
      tx_idx_r   <= 3'd0;
      tx_shift_r <= 8'd0;
      txd_r      <= 1'b1;
      tx_busy_r  <= 1'b0;
    end else begin
      tx_cnt_r  <= (tx_state_r == TX_IDLE || tx_bit_end_s) ? cnt_t'(0) : tx_cnt_r + cnt_t'(1);
      tx_idx_r  <= (tx_state_r != TX_DATA) ? 3'd0 :
                   (tx_bit_end_s ? tx_idx_r + 3'd1 : tx_idx_r);
      if (tx_accept_s)
        tx_shift_r <= bus.wdata[7:0];
      else if (tx_state_r == TX_DATA && tx_bit_end_s)
        tx_shift_r <= {1'b0, tx_shift_r[7:1]};
      else
        tx_shift_r <= tx_shift_r;
      txd_r     <= tx_txd_next_s;
      tx_busy_r <= (tx_next_s != TX_IDLE);
    end
  end

  // Two-flop synchronizer for the asynchronous serial input; idles high.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      rx_meta_r <= 1'b1;
      rx_s_r    <= 1'b1;
    end else begin
      rx_meta_r <= uart_rxd;
      rx_s_r    <= rx_meta_r;
    end
  end

  // RX next-state: half-bit check of the start bit, then mid-bit samples.
  always_comb begin
    rx_next_s   = rx_state_r;
    rx_sample_s = (rx_state_r == RX_START) ? (rx_cnt_r == HALF_LAST) : (rx_cnt_r == BIT_LAST);
    case (rx_state_r)
      RX_IDLE:  rx_next_s = rx_s_r ? RX_IDLE : RX_START;
      RX_START: rx_next_s = rx_sample_s ? (rx_s_r ? RX_IDLE : RX_DATA) : RX_START;
      RX_DATA:  rx_next_s = (rx_sample_s && rx_idx_r == 3'd7) ? RX_STOP : RX_DATA;
      RX_STOP:  rx_next_s = rx_sample_s ? RX_IDLE : RX_STOP;
      default:  rx_next_s = RX_IDLE;
    endcase
    rx_done_s = (rx_state_r == RX_STOP) && rx_sample_s;
  end

  // RX state register.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) rx_state_r <= RX_IDLE;
    else        rx_state_r <= rx_next_s;
  end

  // RX datapath and status flags; a flag being set beats its W1C clear.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      rx_cnt_r    <= '0;
      rx_idx_r    <= 3'd0;
      rx_shift_r  <= 8'd0;
      rx_data_r   <= 8'd0;
      rx_valid_r  <= 1'b0;
      overrun_r   <= 1'b0;
      frame_err_r <= 1'b0;
    end else begin
      rx_cnt_r   <= (rx_state_r == RX_IDLE || rx_sample_s) ? cnt_t'(0) : rx_cnt_r + cnt_t'(1);
      rx_idx_r   <= (rx_state_r != RX_DATA) ? 3'd0 :
                    (rx_sample_s ? rx_idx_r + 3'd1 : rx_idx_r);
      rx_shift_r <= (rx_state_r == RX_DATA && rx_sample_s) ? {rx_s_r, rx_shift_r[7:1]} : rx_shift_r;
      if (rx_done_s && rx_s_r) begin
        rx_data_r  <= rx_shift_r;
        rx_valid_r <= 1'b1;
      end else begin
        rx_data_r  <= rx_data_r;
        rx_valid_r <= rx_read_s ? 1'b0 : rx_valid_r;
      end
      if (rx_done_s && rx_s_r && rx_valid_r && !rx_read_s)
        overrun_r <= 1'b1;
      else if (status_wr_s && bus.wdata[2])
        overrun_r <= 1'b0;
      else
        overrun_r <= overrun_r;
      if (rx_done_s && !rx_s_r)
        frame_err_r <= 1'b1;
      else if (status_wr_s && bus.wdata[3])
        frame_err_r <= 1'b0;
      else
        frame_err_r <= frame_err_r;
    end
  end
endmodule
